// File: rtl/uart_cmd_decoder.sv
// Decodes UART keystrokes (optionally VT100 arrows, `UART_CMD_ARROW_EN) into 3-bit moves in a 4-deep FWFT FIFO.
// Byte in cycle N is queued/flagged at the end of N; a full FIFO without a pop drops the command and pulses o_overflow.
module uart_cmd_decoder #(
  parameter int CMD_FIFO_AW = 2,
  parameter int ESC_TIMEOUT = 1000000,
  parameter int TMO_W       = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic [2:0]           o_cmd,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_ready,
  output logic                 o_bad_key,
  output logic                 o_overflow,
  output logic [CMD_FIFO_AW:0] o_fifo_cnt
);

  localparam int DEPTH = 1 << CMD_FIFO_AW;
  localparam logic [CMD_FIFO_AW:0]   CNT_ONE  = (CMD_FIFO_AW+1)'(1);
  localparam logic [CMD_FIFO_AW:0]   CNT_FULL = (CMD_FIFO_AW+1)'(DEPTH);
  localparam logic [CMD_FIFO_AW-1:0] PTR_ONE  = CMD_FIFO_AW'(1);

  localparam logic [2:0] CMD_UP    = 3'd0;
  localparam logic [2:0] CMD_DOWN  = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_NEW   = 3'd4;

  if ((64'd1 << TMO_W) <= 64'(ESC_TIMEOUT)) begin : g_tmo_w_check
    $error("uart_cmd_decoder: TMO_W too narrow for ESC_TIMEOUT");
  end

  // {hit, cmd} for the plain case-insensitive key map
  function automatic logic [3:0] key_map(input logic [7:0] b);
    case (b)
      8'h77, 8'h57: key_map = {1'b1, CMD_UP};
      8'h73, 8'h53: key_map = {1'b1, CMD_DOWN};
      8'h61, 8'h41: key_map = {1'b1, CMD_LEFT};
      8'h64, 8'h44: key_map = {1'b1, CMD_RIGHT};
      8'h6E, 8'h4E: key_map = {1'b1, CMD_NEW};
      default:      key_map = 4'b0000;
    endcase
  endfunction

  logic [3:0] w_key;
  logic       w_push_req;
  logic       w_bad;
  logic [2:0] w_cmd;

  assign w_key = key_map(i_rx_data);

`ifdef UART_CMD_ARROW_EN
  localparam logic [7:0]       BYTE_ESC  = 8'h1B;
  localparam logic [7:0]       BYTE_LBRK = 8'h5B;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ESC_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ESC, ST_CSI} state_t;

  state_t           r_state;
  logic [TMO_W-1:0] r_tmr;

  always_comb begin
    w_push_req = 1'b0;
    w_bad      = 1'b0;
    w_cmd      = w_key[2:0];
    if (i_rx_valid) begin
      if (r_state == ST_CSI) begin
        w_push_req = 1'b1;
        case (i_rx_data)
          8'h41:   w_cmd = CMD_UP;
          8'h42:   w_cmd = CMD_DOWN;
          8'h43:   w_cmd = CMD_RIGHT;
          8'h44:   w_cmd = CMD_LEFT;
          default: begin
            w_push_req = 1'b0;
            w_bad      = 1'b1;
          end
        endcase
      end else if (!(i_rx_data == BYTE_ESC ||
                     (r_state == ST_ESC && i_rx_data == BYTE_LBRK))) begin
        // A non-sequence byte in ST_ESC falls back to the plain key map
        w_push_req = w_key[3];
        w_bad      = !w_key[3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
    end else if (i_rx_valid) begin
      r_tmr <= '0;
      if (i_rx_data == BYTE_ESC && r_state != ST_CSI)
        r_state <= ST_ESC;
      else if (r_state == ST_ESC && i_rx_data == BYTE_LBRK)
        r_state <= ST_CSI;
      else
        r_state <= ST_IDLE;
    end else if (r_state != ST_IDLE) begin
      if (r_tmr == TMO_LAST) begin
        r_state <= ST_IDLE;
        r_tmr   <= '0;
      end else begin
        r_tmr <= r_tmr + TMO_ONE;
      end
    end
  end
`else
  always_comb begin
    w_push_req = i_rx_valid && w_key[3];
    w_bad      = i_rx_valid && !w_key[3];
    w_cmd      = w_key[2:0];
  end
`endif

  logic [2:0]             r_mem [DEPTH];
  logic [CMD_FIFO_AW-1:0] r_wptr;
  logic [CMD_FIFO_AW-1:0] r_rptr;
  logic [CMD_FIFO_AW:0]   r_cnt;
  logic                   r_bad_key;
  logic                   r_overflow;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push;

  assign w_pop  = (r_cnt != '0) && i_cmd_ready;
  assign w_full = (r_cnt == CNT_FULL);
  // A pop in the same cycle frees the slot the push needs
  assign w_push = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_bad_key  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_bad_key  <= w_bad;
      r_overflow <= w_push_req && w_full && !w_pop;
      if (w_push) begin
        r_mem[r_wptr] <= w_cmd;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cmd       = r_mem[r_rptr];
  assign o_cmd_valid = (r_cnt != '0);
  assign o_fifo_cnt  = r_cnt;
  assign o_bad_key   = r_bad_key;
  assign o_overflow  = r_overflow;

endmodule
